// File: rtl/connect_n_engine.sv
// Connect-N game core: column drops with gravity, one-direction-per-cycle win check,
// draw detection, and red/green LED planes with a turn/winner indicator at pixel [15][0].
module connect_n_engine #(
    parameter int unsigned COLS    = 8,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned WIN_LEN = 4,
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              drop_valid,
    input  logic [COL_W-1:0]  drop_col,
    output logic              drop_ready,
    output logic              illegal,
    output logic              turn,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [7:0]        move_count,
    output logic [15:0][15:0] RedPixels,
    output logic [15:0][15:0] GrnPixels
);

    localparam int unsigned HW    = $clog2(ROWS + 1);
    localparam int unsigned NSLOT = 1 << COL_W;
    localparam int unsigned IND   = 15;

    typedef enum logic [2:0] {
        S_IDLE, S_PLACE, S_CHK0, S_CHK1, S_CHK2, S_CHK3, S_DONE
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col_q;
    logic [HW-1:0]    row_q;
    logic [HW-1:0]    height [NSLOT];

    logic [15:0][15:0] own;
    logic [3:0]        px_row;
    logic [3:0]        px_col;
    logic              col_bad;
    logic              fwd_on;
    logic              bwd_on;
    logic              win;
    int                dx;
    int                dy;
    int                line_len;

    // The pixel planes double as the board: cell (c,r) lives at [ROWS-1-r][c]
    function automatic logic cell_own(input logic [15:0][15:0] p, input int c, input int r);
        if (c < 0 || c >= int'(COLS) || r < 0 || r >= int'(ROWS))
            return 1'b0;
        return p[4'(int'(ROWS) - 1 - r)][4'(c)];
    endfunction

    assign col_bad = (int'(drop_col) >= int'(COLS)) || (height[drop_col] == HW'(ROWS));
    assign px_col  = 4'(col_q);
    assign px_row  = 4'(int'(ROWS) - 1 - int'(height[col_q]));

    // Run length through the placed cell along the direction owned by the current CHK state
    always_comb begin
        own      = turn ? GrnPixels : RedPixels;
        dx       = 1;
        dy       = 0;
        fwd_on   = 1'b1;
        bwd_on   = 1'b1;
        line_len = 1;
        case (state)
            S_CHK1:  begin dx = 0; dy = 1;  end
            S_CHK2:  begin dx = 1; dy = 1;  end
            S_CHK3:  begin dx = 1; dy = -1; end
            default: begin dx = 1; dy = 0;  end
        endcase
        for (int i = 1; i < int'(WIN_LEN); i++) begin
            fwd_on   = fwd_on && cell_own(own, int'(col_q) + i * dx, int'(row_q) + i * dy);
            bwd_on   = bwd_on && cell_own(own, int'(col_q) - i * dx, int'(row_q) - i * dy);
            line_len = line_len + int'(fwd_on) + int'(bwd_on);
        end
        win = (line_len >= int'(WIN_LEN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            height     <= '{default: '0};
            drop_ready <= 1'b1;
            illegal    <= 1'b0;
            turn       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            move_count <= 8'd0;
            RedPixels  <= '0;
            GrnPixels  <= '0;
            RedPixels[IND][0] <= 1'b1;
        end else if (restart) begin
            state      <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            height     <= '{default: '0};
            drop_ready <= 1'b1;
            illegal    <= 1'b0;
            turn       <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            move_count <= 8'd0;
            RedPixels  <= '0;
            GrnPixels  <= '0;
            RedPixels[IND][0] <= 1'b1;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (drop_valid) begin
                        if (col_bad) begin
                            illegal <= 1'b1;
                        end else begin
                            col_q      <= drop_col;
                            drop_ready <= 1'b0;
                            state      <= S_PLACE;
                        end
                    end
                end
                S_PLACE: begin
                    row_q <= height[col_q];
                    if (turn)
                        GrnPixels[px_row][px_col] <= 1'b1;
                    else
                        RedPixels[px_row][px_col] <= 1'b1;
                    height[col_q] <= height[col_q] + HW'(1);
                    move_count    <= move_count + 8'd1;
                    state         <= S_CHK0;
                end
                S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
                    if (win) begin
                        winner            <= {turn, ~turn};
                        game_over         <= 1'b1;
                        RedPixels[IND][0] <= ~turn;
                        GrnPixels[IND][0] <= turn;
                        state             <= S_DONE;
                    end else if (state != S_CHK3) begin
                        state <= state_t'(state + 3'd1);
                    end else if (move_count == 8'(ROWS * COLS)) begin
                        winner            <= 2'b11;
                        game_over         <= 1'b1;
                        RedPixels[IND][0] <= 1'b1;
                        GrnPixels[IND][0] <= 1'b1;
                        state             <= S_DONE;
                    end else begin
                        turn              <= ~turn;
                        drop_ready        <= 1'b1;
                        RedPixels[IND][0] <= turn;
                        GrnPixels[IND][0] <= ~turn;
                        state             <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
